// File: rtl/bus_slave_mux.sv
// Address decoder and response collector for the processing-clock side of the
// system-bus bridge. Each access is routed to one slave register bank and gets
// exactly one registered ack/err/rdata response. A timeout still answers the
// bridge when the selected slave never acknowledges.
module bus_slave_mux #(
    parameter int unsigned N_SLV   = 4,
    parameter int unsigned SLV_LSB = 20,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,

    // Bridge side
    input  logic [31:0]           addr_i,
    input  logic [31:0]           wdata_i,
    input  logic                  wen_i,
    input  logic                  ren_i,
    output logic [31:0]           rdata_o,
    output logic                  err_o,
    output logic                  ack_o,

    // Slave side
    output logic [31:0]           s_addr_o,
    output logic [31:0]           s_wdata_o,
    output logic [N_SLV-1:0]      s_wen_o,
    output logic [N_SLV-1:0]      s_ren_o,
    input  logic [32*N_SLV-1:0]   s_rdata_i,
    input  logic [N_SLV-1:0]      s_err_i,
    input  logic [N_SLV-1:0]      s_ack_i
);

    localparam int unsigned DW     = 32;
    localparam int unsigned SLOT_W = 4;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [N_SLV-1:0]    slot_oh;
    logic                is_read;

    logic [SLOT_W-1:0]   slot_in;
    logic                mapped;
    logic [N_SLV-1:0]    slot_in_oh;
    logic                sel_ack;
    logic                sel_err;
    logic [DW-1:0]       sel_rdata;
    logic                timeout_hit;

    // Slot field of the incoming address and whether a slave exists there
    assign slot_in     = addr_i[SLV_LSB +: SLOT_W];
    assign mapped      = (32'(slot_in) < N_SLV);
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    // One-hot decode of the incoming slot (all-zero when unmapped)
    always_comb begin
        slot_in_oh = '0;
        for (int unsigned k = 0; k < N_SLV; k++) begin
            slot_in_oh[k] = (slot_in == SLOT_W'(k));
        end
    end

    // Response of the selected slave only; other slaves' acks are masked off
    always_comb begin
        sel_rdata = '0;
        for (int unsigned k = 0; k < N_SLV; k++) begin
            sel_rdata = sel_rdata | (s_rdata_i[k*DW +: DW] & {DW{slot_oh[k]}});
        end
    end

    assign sel_ack = |(s_ack_i & slot_oh);
    assign sel_err = |(s_err_i & slot_oh);

    // Access FSM with all bridge and slave outputs registered
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            slot_oh   <= '0;
            is_read   <= 1'b0;
            s_addr_o  <= '0;
            s_wdata_o <= '0;
            s_wen_o   <= '0;
            s_ren_o   <= '0;
            rdata_o   <= '0;
            err_o     <= 1'b0;
            ack_o     <= 1'b0;
        end else begin
            ack_o   <= 1'b0;
            s_wen_o <= '0;
            s_ren_o <= '0;

            case (state)
                ST_IDLE: begin
                    if (wen_i || ren_i) begin
                        s_addr_o  <= addr_i;
                        s_wdata_o <= wdata_i;
                        if (mapped) begin
                            // Write takes priority when both strobes are high
                            if (wen_i) begin
                                s_wen_o <= slot_in_oh;
                            end else begin
                                s_ren_o <= slot_in_oh;
                            end
                            slot_oh <= slot_in_oh;
                            is_read <= ~wen_i;
                            cnt     <= '0;
                            state   <= ST_WAIT;
                        end else begin
                            ack_o   <= 1'b1;
                            err_o   <= 1'b1;
                            rdata_o <= '0;
                        end
                    end
                end

                ST_WAIT: begin
                    // Strobes arriving here are dropped; ack beats timeout
                    if (sel_ack) begin
                        ack_o   <= 1'b1;
                        err_o   <= sel_err;
                        rdata_o <= is_read ? sel_rdata : '0;
                        state   <= ST_IDLE;
                    end else if (timeout_hit) begin
                        ack_o   <= 1'b1;
                        err_o   <= 1'b1;
                        rdata_o <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
